// File: rtl/mbc_pkg.sv
// Shared definitions for the MBC3/MBC30 mapper: RTC register select codes,
// DH bit positions, RTC field limits and the latch FSM encoding.
package mbc_pkg;

  localparam logic [3:0] RTC_S  = 4'h8;
  localparam logic [3:0] RTC_M  = 4'h9;
  localparam logic [3:0] RTC_H  = 4'hA;
  localparam logic [3:0] RTC_DL = 4'hB;
  localparam logic [3:0] RTC_DH = 4'hC;

  localparam int DH_DAY8_BIT  = 0;
  localparam int DH_HALT_BIT  = 6;
  localparam int DH_CARRY_BIT = 7;

  // Last legal value of each field, and the raw field maximum that an
  // out-of-range value climbs to before wrapping without a carry.
  localparam logic [5:0] SEC_LAST     = 6'd59;
  localparam logic [5:0] MIN_LAST     = 6'd59;
  localparam logic [5:0] SM_FIELD_MAX = 6'd63;
  localparam logic [4:0] HOUR_LAST    = 5'd23;
  localparam logic [4:0] H_FIELD_MAX  = 5'd31;
  localparam logic [8:0] DAY_LAST     = 9'd511;

  typedef enum logic {
    LATCH_IDLE  = 1'b0,
    LATCH_ARMED = 1'b1
  } latch_state_e;

  function automatic logic is_rtc_sel(input logic [3:0] sel);
    return (sel >= RTC_S) && (sel <= RTC_DH);
  endfunction

endpackage

// File: rtl/mbc3_rtc_counter.sv
// MBC3 real-time clock: prescaler, live S/M/H/day/halt/carry counters,
// CPU write port, latch FSM with its snapshot registers and the read mux.
module mbc3_rtc_counter
  import mbc_pkg::*;
#(
  parameter int PRESCALE = 32768
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         run_i,
  input  logic         ce_32k_i,
  input  logic         wr_en_i,
  input  logic [3:0]   wr_sel_i,
  input  logic [7:0]   wr_data_i,
  input  logic         latch_wr_i,
  input  logic [7:0]   latch_data_i,
  input  logic [3:0]   rd_sel_i,
  output logic [7:0]   rd_data_o,
  output latch_state_e latch_state_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] ps_q, ps_d;
  logic [5:0]    s_q, s_d, m_q, m_d;
  logic [4:0]    h_q, h_d;
  logic [8:0]    day_q, day_d;
  logic          halt_q, halt_d, carry_q, carry_d;
  logic          tick, c_sec, c_min, c_hour;

  logic [5:0]    ls_q, lm_q;
  logic [4:0]    lh_q;
  logic [8:0]    lday_q;
  logic          lhalt_q, lcarry_q;
  latch_state_e  latch_q;

  function automatic logic [6:0] step_sm(input logic [5:0] v);
    if (v == SEC_LAST)     return {1'b1, 6'd0};
    if (v == SM_FIELD_MAX) return {1'b0, 6'd0};
    return {1'b0, v + 6'd1};
  endfunction

  function automatic logic [5:0] step_h(input logic [4:0] v);
    if (v == HOUR_LAST)   return {1'b1, 5'd0};
    if (v == H_FIELD_MAX) return {1'b0, 5'd0};
    return {1'b0, v + 5'd1};
  endfunction

  always_comb begin
    ps_d    = ps_q;
    s_d     = s_q;
    m_d     = m_q;
    h_d     = h_q;
    day_d   = day_q;
    halt_d  = halt_q;
    carry_d = carry_q;
    tick    = 1'b0;
    c_sec   = 1'b0;
    c_min   = 1'b0;
    c_hour  = 1'b0;
    if (run_i) begin
      if (ce_32k_i && !halt_q) begin
        if (ps_q == PS_LAST) begin
          ps_d = '0;
          tick = 1'b1;
        end else begin
          ps_d = ps_q + PW'(1);
        end
      end
      // A CPU write in the same cycle discards the whole tick cascade.
      if (tick && !wr_en_i) begin
        {c_sec, s_d} = step_sm(s_q);
        if (c_sec) begin
          {c_min, m_d} = step_sm(m_q);
          if (c_min) begin
            {c_hour, h_d} = step_h(h_q);
            if (c_hour) begin
              if (day_q == DAY_LAST) begin
                day_d   = '0;
                carry_d = 1'b1;
              end else begin
                day_d = day_q + 9'd1;
              end
            end
          end
        end
      end
      if (wr_en_i) begin
        case (wr_sel_i)
          RTC_S: begin
            s_d  = wr_data_i[5:0];
            ps_d = '0;
          end
          RTC_M:  m_d = wr_data_i[5:0];
          RTC_H:  h_d = wr_data_i[4:0];
          RTC_DL: day_d[7:0] = wr_data_i;
          RTC_DH: begin
            day_d[8] = wr_data_i[DH_DAY8_BIT];
            halt_d   = wr_data_i[DH_HALT_BIT];
            carry_d  = wr_data_i[DH_CARRY_BIT];
            // Halting parks the prescaler at zero so a restart begins a fresh second.
            if (wr_data_i[DH_HALT_BIT]) ps_d = '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ps_q    <= '0;
      s_q     <= '0;
      m_q     <= '0;
      h_q     <= '0;
      day_q   <= '0;
      halt_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      s_q     <= s_d;
      m_q     <= m_d;
      h_q     <= h_d;
      day_q   <= day_d;
      halt_q  <= halt_d;
      carry_q <= carry_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      latch_q  <= LATCH_IDLE;
      ls_q     <= '0;
      lm_q     <= '0;
      lh_q     <= '0;
      lday_q   <= '0;
      lhalt_q  <= 1'b0;
      lcarry_q <= 1'b0;
    end else if (run_i && latch_wr_i) begin
      if (latch_data_i == 8'h00) begin
        latch_q <= LATCH_ARMED;
      end else begin
        latch_q <= LATCH_IDLE;
        if (latch_q == LATCH_ARMED && latch_data_i == 8'h01) begin
          ls_q     <= s_q;
          lm_q     <= m_q;
          lh_q     <= h_q;
          lday_q   <= day_q;
          lhalt_q  <= halt_q;
          lcarry_q <= carry_q;
        end
      end
    end
  end

  assign latch_state_o = latch_q;

  always_comb begin
    rd_data_o = 8'hFF;
    case (rd_sel_i)
      RTC_S:  rd_data_o = {2'b11, ls_q};
      RTC_M:  rd_data_o = {2'b11, lm_q};
      RTC_H:  rd_data_o = {3'b111, lh_q};
      RTC_DL: rd_data_o = lday_q[7:0];
      RTC_DH: begin
        rd_data_o               = 8'h3E;
        rd_data_o[DH_CARRY_BIT] = lcarry_q;
        rd_data_o[DH_HALT_BIT]  = lhalt_q;
        rd_data_o[DH_DAY8_BIT]  = lday_q[8];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mbc3_rtc.sv
// MBC3/MBC30 cartridge mapper. The real-time clock is built only when
// MBC3_RTC_EN is defined; otherwise this is a plain banked MBC3.
module mbc3_rtc
  import mbc_pkg::*;
#(
  parameter int ROM_BANK_W = 7,
  parameter int RAM_BANK_W = 2,
  parameter int PRESCALE   = 32768
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  ce_cpu,
  input  logic                  ce_32k,
  input  logic                  has_ram,
  input  logic [RAM_BANK_W-1:0] ram_mask,
  input  logic [ROM_BANK_W-1:0] rom_mask,
  input  logic [15:0]           cart_addr,
  input  logic                  cart_wr,
  input  logic [7:0]            cart_di,
  input  logic [7:0]            cram_di,
  inout  wire  [7:0]            cram_do_b,
  inout  wire  [16:0]           cram_addr_b,
  inout  wire  [9:0]            mbc_bank_b,
  inout  wire                   ram_enabled_b,
  inout  wire                   has_battery_b
);

  logic [ROM_BANK_W-1:0] rom_bank_q, rom_wr, rom_eff;
  logic [3:0]            sel_q;
  logic                  ram_en_q;
  logic                  reg_wr;
  logic [8:0]            rom_ext;
  logic [3:0]            ram_ext;
  logic [7:0]            rtc_rd, cram_do;
  logic                  ram_enabled;

  assign reg_wr = enable & ce_cpu & cart_wr & ~cart_addr[15];
  assign rom_wr = ROM_BANK_W'(cart_di);

  // Bank registers sit at their reset values whenever the mapper is deselected.
  always_ff @(posedge clk_sys) begin
    if (!reset_n || !enable) begin
      rom_bank_q <= ROM_BANK_W'(1);
      sel_q      <= 4'd0;
      ram_en_q   <= 1'b0;
    end else if (reg_wr) begin
      case (cart_addr[14:13])
        2'b00: ram_en_q <= (cart_di[3:0] == 4'hA);
        2'b01: rom_bank_q <= (rom_wr == '0) ? ROM_BANK_W'(1) : rom_wr;
        2'b10: sel_q <= cart_di[3:0];
        default: ;
      endcase
    end
  end

`ifdef MBC3_RTC_EN
  logic         rtc_wr, latch_wr;
  latch_state_e unused_latch_state;

  assign rtc_wr   = enable & ce_cpu & cart_wr & (cart_addr[15:13] == 3'b101)
                  & ram_en_q & is_rtc_sel(sel_q);
  assign latch_wr = reg_wr & (cart_addr[14:13] == 2'b11);

  mbc3_rtc_counter #(
    .PRESCALE(PRESCALE)
  ) u_rtc (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .run_i        (enable),
    .ce_32k_i     (ce_32k),
    .wr_en_i      (rtc_wr),
    .wr_sel_i     (sel_q),
    .wr_data_i    (cart_di),
    .latch_wr_i   (latch_wr),
    .latch_data_i (cart_di),
    .rd_sel_i     (sel_q),
    .rd_data_o    (rtc_rd),
    .latch_state_o(unused_latch_state)
  );
`else
  logic unused_rtc;
  assign unused_rtc = ^{ce_32k, cart_di};
  assign rtc_rd     = 8'hFF;
`endif

  assign rom_eff     = ((cart_addr[15:14] == 2'b00) ? '0 : rom_bank_q) & rom_mask;
  assign rom_ext     = 9'(rom_eff);
  assign ram_ext     = 4'(sel_q[RAM_BANK_W-1:0] & ram_mask);
  assign ram_enabled = ram_en_q & has_ram & ~sel_q[3];

  always_comb begin
    if (ram_en_q && sel_q[3])     cram_do = rtc_rd;
    else if (ram_en_q && has_ram) cram_do = cram_di;
    else                          cram_do = 8'hFF;
  end

  assign cram_do_b     = enable ? cram_do : 8'hzz;
  assign cram_addr_b   = enable ? {ram_ext, cart_addr[12:0]} : 17'hz_zzzz;
  assign mbc_bank_b    = enable ? {rom_ext, cart_addr[13]} : 10'hzzz;
  assign ram_enabled_b = enable ? ram_enabled : 1'bz;
  assign has_battery_b = enable ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_mbc3_rtc.sv
// Self-checking bench for mbc3_rtc: bank-mapping vector table, randomized
// bank writes, RTC corner sequences and a randomized RTC run against a model.
module tb_mbc3_rtc;

  localparam int ROM_W = 8;
  localparam int RAM_W = 2;
  localparam int PS    = 4;

  logic             clk_sys = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable  = 1'b1;
  logic             ce_cpu  = 1'b0;
  logic             ce_32k  = 1'b0;
  logic             has_ram = 1'b1;
  logic [RAM_W-1:0] ram_mask = '1;
  logic [ROM_W-1:0] rom_mask = '1;
  logic [15:0]      cart_addr = 16'h0000;
  logic             cart_wr = 1'b0;
  logic [7:0]       cart_di = 8'h00;
  logic [7:0]       cram_di = 8'h5A;
  wire  [7:0]       cram_do_b;
  wire  [16:0]      cram_addr_b;
  wire  [9:0]       mbc_bank_b;
  wire              ram_enabled_b;
  wire              has_battery_b;

  mbc3_rtc #(.ROM_BANK_W(ROM_W), .RAM_BANK_W(RAM_W), .PRESCALE(PS)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable), .ce_cpu(ce_cpu),
    .ce_32k(ce_32k), .has_ram(has_ram), .ram_mask(ram_mask), .rom_mask(rom_mask),
    .cart_addr(cart_addr), .cart_wr(cart_wr), .cart_di(cart_di), .cram_di(cram_di),
    .cram_do_b(cram_do_b), .cram_addr_b(cram_addr_b), .mbc_bank_b(mbc_bank_b),
    .ram_enabled_b(ram_enabled_b), .has_battery_b(has_battery_b)
  );

  // Clock and reset
  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    cart_addr = a; cart_di = d; cart_wr = 1'b1; ce_cpu = 1'b1;
    @(negedge clk_sys);
    cart_wr = 1'b0; ce_cpu = 1'b0;
  endtask

  task automatic pulse_raw(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys); ce_32k = 1'b1;
      @(negedge clk_sys); ce_32k = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_sys); reset_n = 1'b0;
    @(negedge clk_sys); reset_n = 1'b1;
  endtask

`ifdef MBC3_RTC_EN
  // Behavioural RTC: plain integer fields, advanced one whole second at a time.
  int m_s, m_m, m_h, m_day, m_halt, m_carry, m_phase, m_armed;
  int l_s, l_m, l_h, l_day, l_halt, l_carry;

  function automatic void model_reset();
    m_s = 0; m_m = 0; m_h = 0; m_day = 0; m_halt = 0; m_carry = 0; m_phase = 0; m_armed = 0;
    l_s = 0; l_m = 0; l_h = 0; l_day = 0; l_halt = 0; l_carry = 0;
  endfunction

  function automatic void model_second();
    if (m_s != 59) begin m_s = (m_s + 1) % 64; return; end
    m_s = 0;
    if (m_m != 59) begin m_m = (m_m + 1) % 64; return; end
    m_m = 0;
    if (m_h != 23) begin m_h = (m_h + 1) % 32; return; end
    m_h = 0;
    if (m_day == 511) begin m_day = 0; m_carry = 1; end
    else m_day = m_day + 1;
  endfunction

  function automatic void model_ce(input bit write_hit);
    if (m_halt != 0) return;
    m_phase++;
    if (m_phase == PS) begin
      m_phase = 0;
      if (!write_hit) model_second();
    end
  endfunction

  function automatic void model_write(input int code, input int d);
    case (code)
      8:  begin m_s = d % 64; m_phase = 0; end
      9:  m_m = d % 64;
      10: m_h = d % 32;
      11: m_day = (m_day / 256) * 256 + d;
      12: begin
        m_day   = (m_day % 256) + (d % 2) * 256;
        m_halt  = (d / 64) % 2;
        m_carry = (d / 128) % 2;
        if (m_halt != 0) m_phase = 0;
      end
      default: ;
    endcase
  endfunction

  function automatic void model_latch(input int d);
    if (d == 0) begin m_armed = 1; return; end
    if (m_armed != 0 && d == 1) begin
      l_s = m_s; l_m = m_m; l_h = m_h; l_day = m_day; l_halt = m_halt; l_carry = m_carry;
    end
    m_armed = 0;
  endfunction

  function automatic logic [7:0] model_rd(input int code);
    case (code)
      8:  return 8'(192 + l_s);
      9:  return 8'(192 + l_m);
      10: return 8'(224 + l_h);
      11: return 8'(l_day % 256);
      12: return 8'(l_carry * 128 + l_halt * 64 + 62 + l_day / 256);
      default: return 8'hFF;
    endcase
  endfunction

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_raw(1);
      model_ce(1'b0);
    end
  endtask

  task automatic rtc_write(input int code, input int d);
    cpu_write(16'h4000, 8'(code));
    cpu_write(16'hA000, 8'(d));
    model_write(code, d);
  endtask

  task automatic latch(input int d);
    cpu_write(16'h6000, 8'(d));
    model_latch(d);
  endtask

  task automatic rtc_get(input int code, output logic [7:0] v);
    cpu_write(16'h4000, 8'(code));
    cart_addr = 16'hA000;
    #1 v = cram_do_b;
  endtask

  task automatic rtc_expect(input string name, input int code, input logic [7:0] exp);
    logic [7:0] v;
    rtc_get(code, v);
    chk(name, {9'd0, v}, {9'd0, exp});
  endtask

  task automatic rtc_model_check(input int code);
    logic [7:0] v;
    exp_q.push_back(model_rd(code));
    rtc_get(code, v);
    chk($sformatf("rand_rtc_%0h", code), {9'd0, v}, {9'd0, exp_q.pop_front()});
  endtask
`endif

  typedef struct {
    logic [15:0] wa;
    logic [7:0]  wd;
    logic [15:0] ra;
    logic [7:0]  rmask;
    logic [1:0]  amask;
    logic [9:0]  e_bank;
    logic [3:0]  e_cb;
    logic        e_ren;
    logic [7:0]  e_do;
  } vec_t;

  vec_t vt[11];

  initial begin
    logic [7:0]  br_rom, d, rb;
    logic [3:0]  br_sel;
    logic        br_en;
    logic [15:0] ra;

    vt[0]  = '{16'h2000, 8'h00, 16'h4000, 8'hFF, 2'b11, 10'h002, 4'd0, 1'b0, 8'hFF};
    vt[1]  = '{16'h2000, 8'h85, 16'h4000, 8'hFF, 2'b11, 10'h10A, 4'd0, 1'b0, 8'hFF};
    vt[2]  = '{16'h2000, 8'h85, 16'h6000, 8'h3F, 2'b11, 10'h00B, 4'd0, 1'b0, 8'hFF};
    vt[3]  = '{16'h0000, 8'h0A, 16'h0000, 8'hFF, 2'b11, 10'h000, 4'd0, 1'b1, 8'h5A};
    vt[4]  = '{16'h4000, 8'h03, 16'hA000, 8'hFF, 2'b11, 10'h10B, 4'd3, 1'b1, 8'h5A};
    vt[5]  = '{16'h0000, 8'h00, 16'hA000, 8'hFF, 2'b11, 10'h10B, 4'd3, 1'b0, 8'hFF};
    vt[6]  = '{16'h0000, 8'h1A, 16'h2000, 8'hFF, 2'b11, 10'h001, 4'd3, 1'b1, 8'h5A};
    vt[7]  = '{16'h4000, 8'h06, 16'hBFFF, 8'hFF, 2'b01, 10'h10B, 4'd0, 1'b1, 8'h5A};
    vt[8]  = '{16'h2000, 8'h40, 16'h7FFF, 8'hFF, 2'b11, 10'h081, 4'd2, 1'b1, 8'h5A};
    vt[9]  = '{16'h1FFF, 8'h0B, 16'h4000, 8'hFF, 2'b11, 10'h080, 4'd2, 1'b0, 8'hFF};
    vt[10] = '{16'hA000, 8'h00, 16'h4000, 8'hFF, 2'b11, 10'h080, 4'd2, 1'b0, 8'hFF};

    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
`ifdef MBC3_RTC_EN
    model_reset();
`endif
    cart_addr = 16'h4000;
    #1;
    chk("rst_bank", {7'd0, mbc_bank_b}, 17'h002);
    chk("rst_ren", {16'd0, ram_enabled_b}, 17'd0);
    chk("rst_do", {9'd0, cram_do_b}, 17'h0FF);
    chk("rst_caddr", cram_addr_b, 17'h00000);
    chk("rst_batt", {16'd0, has_battery_b}, 17'd1);

    // Bank mapping vector table
    for (int i = 0; i < 11; i++) begin
      cpu_write(vt[i].wa, vt[i].wd);
      rom_mask  = vt[i].rmask;
      ram_mask  = vt[i].amask;
      cart_addr = vt[i].ra;
      #1;
      chk($sformatf("vec%0d_bank", i), {7'd0, mbc_bank_b}, {7'd0, vt[i].e_bank});
      chk($sformatf("vec%0d_caddr", i), cram_addr_b, {vt[i].e_cb, vt[i].ra[12:0]});
      chk($sformatf("vec%0d_ren", i), {16'd0, ram_enabled_b}, {16'd0, vt[i].e_ren});
      chk($sformatf("vec%0d_do", i), {9'd0, cram_do_b}, {9'd0, vt[i].e_do});
    end

    // Randomized bank-register traffic against a register-level model
    br_rom = 8'h40; br_sel = 4'd6; br_en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          d = ($urandom_range(0, 1) == 1) ? {4'($urandom_range(0, 15)), 4'hA} : 8'($urandom);
          cpu_write(16'($urandom_range(16'h0000, 16'h1FFF)), d);
          br_en = (d[3:0] == 4'hA);
        end
        1: begin
          d = 8'($urandom);
          cpu_write(16'($urandom_range(16'h2000, 16'h3FFF)), d);
          br_rom = (d == 8'h00) ? 8'h01 : d;
        end
        default: begin
          d = {4'($urandom_range(0, 15)), 1'b0, 3'($urandom_range(0, 7))};
          cpu_write(16'($urandom_range(16'h4000, 16'h5FFF)), d);
          br_sel = d[3:0];
        end
      endcase
      has_ram   = 1'($urandom_range(0, 1));
      cram_di   = 8'($urandom);
      rom_mask  = 8'($urandom);
      ram_mask  = 2'($urandom);
      ra        = 16'($urandom);
      cart_addr = ra;
      #1;
      rb = (ra[15:14] == 2'b00) ? 8'h00 : br_rom;
      chk("rand_bank", {7'd0, mbc_bank_b}, {7'd0, rb & rom_mask, ra[13]});
      chk("rand_caddr", cram_addr_b, {2'b00, br_sel[1:0] & ram_mask, ra[12:0]});
      chk("rand_ren", {16'd0, ram_enabled_b}, {16'd0, br_en & has_ram});
      chk("rand_do", {9'd0, cram_do_b}, {9'd0, (br_en && has_ram) ? cram_di : 8'hFF});
    end
    has_ram = 1'b1; rom_mask = '1; ram_mask = '1; cram_di = 8'h5A;

    cpu_write(16'h0000, 8'h0A);
`ifdef MBC3_RTC_EN
    // Full rollover sets the sticky day carry
    rtc_write(9, 59); rtc_write(10, 23); rtc_write(11, 8'hFF); rtc_write(12, 8'h01);
    rtc_write(8, 59);
    pulse(PS);
    latch(0); latch(1);
    rtc_expect("roll_s", 8, 8'hC0);
    rtc_expect("roll_m", 9, 8'hC0);
    rtc_expect("roll_h", 10, 8'hE0);
    rtc_expect("roll_dl", 11, 8'h00);
    rtc_expect("roll_dh", 12, 8'hBE);
    cart_addr = 16'hA000;
    #1 chk("rtc_ren", {16'd0, ram_enabled_b}, 17'd0);

    // Out-of-range seconds wrap without carrying into minutes
    rtc_write(9, 5); rtc_write(8, 62);
    pulse(2 * PS);
    latch(0); latch(1);
    rtc_expect("oor_s", 8, 8'hC0);
    rtc_expect("oor_m", 9, 8'hC5);
    rtc_expect("carry_sticky", 12, 8'hBE);

    // Halt freezes counting; release restarts from a cleared prescaler
    rtc_write(12, 8'h40);
    pulse(3 * PS);
    latch(0); latch(1);
    rtc_expect("halt_s", 8, 8'hC0);
    rtc_expect("halt_dh", 12, 8'h7E);
    rtc_write(12, 8'h00);
    pulse(PS - 1);
    latch(0); latch(1);
    rtc_expect("resume_early", 8, 8'hC0);
    pulse(1);
    latch(0); latch(1);
    rtc_expect("resume_tick", 8, 8'hC1);

    // Broken latch sequence leaves the snapshot alone
    rtc_write(8, 10);
    latch(0); latch(2); latch(1);
    rtc_expect("nolatch_s", 8, 8'hC1);
    latch(0); latch(1);
    rtc_expect("relatch_s", 8, 8'hCA);

    // Tick coincident with a minutes write: write wins, seconds hold
    rtc_write(8, 0);
    pulse(PS - 1);
    cpu_write(16'h4000, 8'h09);
    @(negedge clk_sys);
    ce_32k = 1'b1; cart_addr = 16'hA000; cart_di = 8'h2A; cart_wr = 1'b1; ce_cpu = 1'b1;
    @(negedge clk_sys);
    ce_32k = 1'b0; cart_wr = 1'b0; ce_cpu = 1'b0;
    model_ce(1'b1); model_write(9, 8'h2A);
    latch(0); latch(1);
    rtc_expect("coin_s", 8, 8'hC0);
    rtc_expect("coin_m", 9, 8'hEA);
    pulse(PS);
    latch(0); latch(1);
    rtc_expect("coin_after", 8, 8'hC1);

    // Deselect freezes the RTC without clearing it
    rtc_write(8, 5);
    @(negedge clk_sys); enable = 1'b0;
    pulse_raw(2 * PS);
    @(negedge clk_sys); enable = 1'b1;
    cart_addr = 16'h4000;
    #1 chk("reen_bank", {7'd0, mbc_bank_b}, 17'h002);
    cpu_write(16'h0000, 8'h0A);
    latch(0); latch(1);
    rtc_expect("frozen_s", 8, 8'hC5);

    // Randomized RTC traffic against the behavioural model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: rtc_write($urandom_range(8, 12), $urandom_range(0, 255));
        1: pulse($urandom_range(1, 2 * PS));
        2: begin latch(0); latch(1); rtc_model_check($urandom_range(8, 12)); end
        default: begin latch($urandom_range(0, 3)); rtc_model_check($urandom_range(8, 12)); end
      endcase
    end
`else
    // Without the RTC, selects 8..C read open bus and RTC/latch writes do nothing
    cpu_write(16'h4000, 8'h08);
    cart_addr = 16'hA000;
    #1 chk("nortc_do_s", {9'd0, cram_do_b}, 17'h0FF);
    chk("nortc_ren", {16'd0, ram_enabled_b}, 17'd0);
    cpu_write(16'hA000, 8'h3B);
    cart_addr = 16'hA000;
    #1 chk("nortc_wr", {9'd0, cram_do_b}, 17'h0FF);
    cpu_write(16'h6000, 8'h00);
    cpu_write(16'h6000, 8'h01);
    cart_addr = 16'h4000;
    #1 chk("nortc_latch", {7'd0, mbc_bank_b}, {7'd0, br_rom, 1'b0});
    cpu_write(16'h4000, 8'h0C);
    cart_addr = 16'hA000;
    #1 chk("nortc_do_dh", {9'd0, cram_do_b}, 17'h0FF);
    cpu_write(16'h4000, 8'h00);
    cart_addr = 16'hA000;
    #1 chk("nortc_ram", {9'd0, cram_do_b}, 17'h05A);
`endif

    // Deselected mapper releases every shared net
    @(negedge clk_sys); enable = 1'b0;
    #1;
    chk("z_do", {16'd0, cram_do_b === 8'hzz}, 17'd1);
    chk("z_caddr", {16'd0, cram_addr_b === 17'hz_zzzz}, 17'd1);
    chk("z_bank", {16'd0, mbc_bank_b === 10'hzzz}, 17'd1);
    chk("z_ren", {16'd0, ram_enabled_b === 1'bz}, 17'd1);
    chk("z_batt", {16'd0, has_battery_b === 1'bz}, 17'd1);
    @(negedge clk_sys); enable = 1'b1;

    // Reset in the middle of a count
    cpu_write(16'h2000, 8'h33);
    cpu_write(16'h0000, 8'h0A);
`ifdef MBC3_RTC_EN
    rtc_write(8, 20);
    pulse(PS - 1);
`endif
    do_reset();
`ifdef MBC3_RTC_EN
    model_reset();
`endif
    cart_addr = 16'h4000;
    #1;
    chk("mid_rst_bank", {7'd0, mbc_bank_b}, 17'h002);
    chk("mid_rst_ren", {16'd0, ram_enabled_b}, 17'd0);
    chk("mid_rst_do", {9'd0, cram_do_b}, 17'h0FF);
`ifdef MBC3_RTC_EN
    cpu_write(16'h0000, 8'h0A);
    rtc_expect("mid_rst_ls", 8, 8'hC0);
    rtc_expect("mid_rst_ldh", 12, 8'h3E);
    pulse(PS - 1);
    latch(0); latch(1);
    rtc_expect("mid_rst_s", 8, 8'hC0);
    pulse(1);
    latch(0); latch(1);
    rtc_expect("mid_rst_tick", 8, 8'hC1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
